// File: rtl/bit_unstuff_block_pkg.sv
// rtl/bit_unstuff_block_pkg.sv - shared SIE bit-stuffing constants and run-state type
package bit_unstuff_block_pkg;

    // Same constants the transmit-side stuffer uses
    localparam int SIE_MAX_ONES = 6;
    localparam int SIE_BYTE_W   = 8;
    localparam int SIE_CNT_W    = 3;

    // COUNT: fewer than MAX_ONES ones seen; STUFF_SLOT: next bit must be a stuff zero
    typedef enum logic {
        RUN_COUNT      = 1'b0,
        RUN_STUFF_SLOT = 1'b1
    } run_state_t;

endpackage

// File: rtl/bit_unstuff_block_byte_assembler.sv
// rtl/bit_unstuff_block_byte_assembler.sv - LSB-first byte assembler for unstuffed data bits
module sie_byte_assembler
    import bit_unstuff_block_pkg::*;
#(
    parameter int BYTE_W = SIE_BYTE_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid
);

    localparam int BC_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(BYTE_W - 1);

    logic [BYTE_W-1:0] shift_reg;
    logic [BC_W-1:0]   bit_cnt;
    logic [BYTE_W-1:0] shifted;

    // New bits enter at the MSB so the first received bit lands in bit 0
    always_comb begin
        shifted = {bit_in, shift_reg[BYTE_W-1:1]};
    end

    // Shift data bits in, publish a byte on every BYTE_W-th data bit, drop partial on clear
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (clear) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (shift_en) begin
                if (bit_cnt == LAST_BIT) begin
                    byte_out   <= shifted;
                    byte_valid <= 1'b1;
                    shift_reg  <= '0;
                    bit_cnt    <= '0;
                end else begin
                    shift_reg <= shifted;
                    bit_cnt   <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bit_unstuff_block.sv
// rtl/bit_unstuff_block.sv - receive-side bit unstuffer with stuff-error detection and byte assembly
module bit_unstuff_block
    import bit_unstuff_block_pkg::*;
#(
    parameter int MAX_ONES = SIE_MAX_ONES,
    parameter int BYTE_W   = SIE_BYTE_W,
    parameter int CNT_W    = SIE_CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EnData,
    input  logic              Clr,
    input  logic              Data_in,
    output logic              Data_out,
    output logic              Data_valid,
    output logic              Stuffed,
    output logic              Stuff_err,
    output logic [BYTE_W-1:0] Byte_out,
    output logic              Byte_valid
);

    localparam logic [CNT_W-1:0] ONES_LAST = CNT_W'(MAX_ONES - 1);

    run_state_t       state;
    logic [CNT_W-1:0] ones;
    logic             take;
    logic             in_slot;
    logic             asm_shift;
    logic             asm_clear;

    // Decide what this cycle's sample means for the byte assembler
    always_comb begin
        take      = EnData & ~Clr;
        in_slot   = (state == RUN_STUFF_SLOT);
        asm_shift = take & ~in_slot;
        asm_clear = Clr | (take & in_slot & Data_in);
    end

    // Run-length FSM: count ones, strip the stuff zero, flag a one in the stuff slot
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= RUN_COUNT;
            ones       <= '0;
            Data_out   <= 1'b0;
            Data_valid <= 1'b0;
            Stuffed    <= 1'b0;
            Stuff_err  <= 1'b0;
        end else begin
            Data_valid <= 1'b0;
            Stuffed    <= 1'b0;
            Stuff_err  <= 1'b0;
            if (Clr) begin
                state <= RUN_COUNT;
                ones  <= '0;
            end else if (EnData) begin
                case (state)
                    RUN_STUFF_SLOT: begin
                        state <= RUN_COUNT;
                        ones  <= '0;
                        if (Data_in) begin
                            Stuff_err <= 1'b1;
                        end else begin
                            Stuffed <= 1'b1;
                        end
                    end
                    default: begin
                        Data_valid <= 1'b1;
                        Data_out   <= Data_in;
                        if (Data_in) begin
                            ones <= ones + 1'b1;
                            if (ones == ONES_LAST) begin
                                state <= RUN_STUFF_SLOT;
                            end
                        end else begin
                            ones <= '0;
                        end
                    end
                endcase
            end
        end
    end

    sie_byte_assembler #(
        .BYTE_W (BYTE_W)
    ) u_asm (
        .clk        (CLK),
        .resetn     (RST),
        .clear      (asm_clear),
        .shift_en   (asm_shift),
        .bit_in     (Data_in),
        .byte_out   (Byte_out),
        .byte_valid (Byte_valid)
    );

endmodule

// File: tb/tb_bit_unstuff_block.sv
// tb/tb_bit_unstuff_block.sv - scoreboard bench for bit_unstuff_block
module tb_bit_unstuff_block;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EnData = 1'b0;
    logic       Clr = 1'b0;
    logic       Data_in = 1'b0;
    logic       Data_out;
    logic       Data_valid;
    logic       Stuffed;
    logic       Stuff_err;
    logic [7:0] Byte_out;
    logic       Byte_valid;

    bit_unstuff_block dut (
        .CLK        (CLK),
        .RST        (RST),
        .EnData     (EnData),
        .Clr        (Clr),
        .Data_in    (Data_in),
        .Data_out   (Data_out),
        .Data_valid (Data_valid),
        .Stuffed    (Stuffed),
        .Stuff_err  (Stuff_err),
        .Byte_out   (Byte_out),
        .Byte_valid (Byte_valid)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       dv;
        logic       dout;
        logic       stf;
        logic       err;
        logic       bv;
        logic [7:0] byte_v;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // reference model state
    int         m_ones = 0;
    int         m_cnt = 0;
    logic [7:0] m_shift = '0;
    logic [7:0] m_byte = '0;

    // observed tallies, reset per test
    int         n_dv, n_stf, n_err, n_bv;
    logic [7:0] seen_bytes[$];

    task automatic clear_tally();
        n_dv = 0; n_stf = 0; n_err = 0; n_bv = 0;
        seen_bytes.delete();
    endtask

    task automatic drive(input logic rst, input logic en, input logic clr, input logic d);
        exp_t e;
        exp_t got;
        e.dv = 0; e.dout = 0; e.stf = 0; e.err = 0; e.bv = 0;
        if (!rst) begin
            m_ones = 0; m_cnt = 0; m_shift = '0; m_byte = '0;
        end else if (clr) begin
            m_ones = 0; m_cnt = 0; m_shift = '0;
        end else if (en) begin
            if (m_ones == 6) begin
                m_ones = 0;
                if (d) begin
                    e.err = 1; m_cnt = 0; m_shift = '0;
                end else begin
                    e.stf = 1;
                end
            end else begin
                e.dv = 1; e.dout = d;
                m_ones = d ? m_ones + 1 : 0;
                m_shift = {d, m_shift[7:1]};
                if (m_cnt == 7) begin
                    m_byte = m_shift; e.bv = 1; m_cnt = 0; m_shift = '0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
        e.byte_v = m_byte;
        sb.push_back(e);
        RST = rst; EnData = en; Clr = clr; Data_in = d;
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        checks++;
        if (Data_valid !== got.dv) begin
            errors++; $display("FAIL data_valid got %b exp %b at %0t", Data_valid, got.dv, $time);
        end
        if (got.dv) begin
            checks++;
            if (Data_out !== got.dout) begin
                errors++; $display("FAIL data_out got %b exp %b at %0t", Data_out, got.dout, $time);
            end
        end
        checks++;
        if (Stuffed !== got.stf) begin
            errors++; $display("FAIL stuffed got %b exp %b at %0t", Stuffed, got.stf, $time);
        end
        checks++;
        if (Stuff_err !== got.err) begin
            errors++; $display("FAIL stuff_err got %b exp %b at %0t", Stuff_err, got.err, $time);
        end
        checks++;
        if (Byte_valid !== got.bv) begin
            errors++; $display("FAIL byte_valid got %b exp %b at %0t", Byte_valid, got.bv, $time);
        end
        checks++;
        if (Byte_out !== got.byte_v) begin
            errors++; $display("FAIL byte_out got %h exp %h at %0t", Byte_out, got.byte_v, $time);
        end
        if (Data_valid === 1'b1) n_dv++;
        if (Stuffed === 1'b1) n_stf++;
        if (Stuff_err === 1'b1) n_err++;
        if (Byte_valid === 1'b1) begin
            n_bv++; seen_bytes.push_back(Byte_out);
        end
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) drive(1, 1, 0, bits[i]);
    endtask

    task automatic do_clr();
        drive(1, 0, 1, 1);
    endtask

    task automatic test_reset();
        drive(0, 1, 1, 1);
        drive(0, 0, 0, 0);
        checks++;
        if ({Data_valid, Stuffed, Stuff_err, Byte_valid, Data_out, Byte_out} !== 13'h0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", {Data_valid, Stuffed, Stuff_err, Byte_valid, Data_out, Byte_out});
        end
    endtask

    task automatic test_basic_unstuff();
        do_clr(); clear_tally();
        send_bits(32'b1011_1111, 8);
        checks++;
        if (n_dv != 7) begin errors++; $display("FAIL basic_dv_count got %0d exp 7", n_dv); end
        checks++;
        if (n_stf != 1) begin errors++; $display("FAIL basic_stuffed_count got %0d exp 1", n_stf); end
        // one counted after the stuff bit plus five more reaches the stuff slot again
        clear_tally();
        send_bits(32'b0011111, 7);
        checks++;
        if (n_stf != 1) begin errors++; $display("FAIL basic_restart_stuff got %0d exp 1", n_stf); end
    endtask

    task automatic test_byte_assembly();
        do_clr(); clear_tally();
        send_bits(32'b1010_0101, 8);
        checks++;
        if (n_bv != 1) begin errors++; $display("FAIL assemble_bv_count got %0d exp 1", n_bv); end
        checks++;
        if (seen_bytes.size() < 1 || seen_bytes[0] !== 8'hA5) begin
            errors++; $display("FAIL assemble_byte got %h exp a5", Byte_out);
        end
    endtask

    task automatic test_stuff_boundary();
        do_clr(); clear_tally();
        send_bits(32'b1_1011_1111, 9);
        send_bits(32'h0, 8);
        checks++;
        if (n_stf != 1) begin errors++; $display("FAIL boundary_stuffed got %0d exp 1", n_stf); end
        checks++;
        if (n_dv != 16) begin errors++; $display("FAIL boundary_dv got %0d exp 16", n_dv); end
        checks++;
        if (seen_bytes.size() != 2) begin
            errors++; $display("FAIL boundary_bytes got %0d exp 2", seen_bytes.size());
        end else begin
            checks++;
            if (seen_bytes[0] !== 8'hFF || seen_bytes[1] !== 8'h00) begin
                errors++; $display("FAIL boundary_values got %h %h exp ff 00", seen_bytes[0], seen_bytes[1]);
            end
        end
    endtask

    task automatic test_stuff_error();
        do_clr(); clear_tally();
        send_bits(32'b1111_1110, 8);
        checks++;
        if (n_err != 1) begin errors++; $display("FAIL error_count got %0d exp 1", n_err); end
        checks++;
        if (n_bv != 0) begin errors++; $display("FAIL error_no_byte got %0d exp 0", n_bv); end
        clear_tally();
        send_bits(32'b1010_0101, 8);
        checks++;
        if (seen_bytes.size() != 1 || Byte_out !== 8'hA5) begin
            errors++; $display("FAIL error_recover got %h exp a5", Byte_out);
        end
    endtask

    task automatic test_gaps();
        do_clr(); clear_tally();
        send_bits(32'b111, 3);
        for (int i = 0; i < 4; i++) drive(1, 0, 0, i[0]);
        checks++;
        if (n_dv != 3) begin errors++; $display("FAIL gap_quiet got %0d exp 3", n_dv); end
        send_bits(32'b0111, 4);
        checks++;
        if (n_stf != 1) begin errors++; $display("FAIL gap_stuffed got %0d exp 1", n_stf); end
        checks++;
        if (n_dv != 6) begin errors++; $display("FAIL gap_dv got %0d exp 6", n_dv); end
    endtask

    task automatic test_clr_mid();
        do_clr(); clear_tally();
        send_bits(32'b01101, 5);
        do_clr();
        send_bits(32'b1010_0101, 8);
        checks++;
        if (n_bv != 1 || Byte_out !== 8'hA5) begin
            errors++; $display("FAIL clr_mid got %h bv %0d exp a5 bv 1", Byte_out, n_bv);
        end
    endtask

    task automatic test_reset_mid();
        do_clr(); clear_tally();
        send_bits(32'b1_1111, 5);
        drive(0, 1, 0, 1);
        checks++;
        if (Byte_out !== 8'h00) begin errors++; $display("FAIL reset_mid_byte got %h exp 00", Byte_out); end
        clear_tally();
        send_bits(32'b1010_0101, 8);
        checks++;
        if (n_bv != 1 || Byte_out !== 8'hA5) begin
            errors++; $display("FAIL reset_mid_recover got %h exp a5", Byte_out);
        end
    endtask

    task automatic test_back_to_back();
        do_clr();
        for (int i = 0; i < 400; i++) begin
            logic en, d, clr;
            en  = ($urandom_range(0, 9) != 0);
            d   = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 99) == 0);
            drive(1, en, clr, d);
        end
    endtask

    initial begin
        test_reset();
        test_basic_unstuff();
        test_byte_assembly();
        test_stuff_boundary();
        test_stuff_error();
        test_gaps();
        test_clr_mid();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
